// File: rtl/multicycle_alu.sv
// Sequential WIDTH-bit ALU with START/BUSY/DONE handshake.
// Shift-add multiply and one-bit-per-cycle shifts/rotates.
module multicycle_alu #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [2:0]         SELECT,
  input  logic               CHOICE,
  input  logic [WIDTH-1:0]   DATA1,
  input  logic [WIDTH-1:0]   DATA2,
  input  logic [SHAMT_W-1:0] SHIFT,
  output logic [WIDTH-1:0]   RESULT,
  output logic               ZERO,
  output logic               CARRY,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  typedef enum logic [2:0] {
    OP_FWD   = 3'b000,
    OP_ADD   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_MUL   = 3'b100,
    OP_SRA   = 3'b101,
    OP_ROR   = 3'b110,
    OP_SHIFT = 3'b111
  } op_t;

  localparam logic [SHAMT_W-1:0] W_CNT = SHAMT_W'(WIDTH);

  state_t             state;
  op_t                op;
  logic               choice;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;

  logic [SHAMT_W-1:0] sat;
  logic [SHAMT_W-1:0] load_cnt;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   nxt;
  logic               cy;
  logic               last;

  // cnt holds remaining EXEC steps; single-cycle ops and n=0 load zero
  always_comb begin
    sat      = (SHIFT >= W_CNT) ? W_CNT : SHIFT;
    load_cnt = '0;
    unique case (op_t'(SELECT))
      OP_MUL:           load_cnt = W_CNT;
      OP_SRA, OP_SHIFT: load_cnt = sat;
      OP_ROR:           load_cnt = SHIFT % W_CNT;
      default:          load_cnt = '0;
    endcase
  end

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    nxt  = acc;
    cy   = 1'b0;
    last = (cnt <= SHAMT_W'(1));
    unique case (op)
      OP_FWD: nxt = b;
      OP_ADD: begin
        nxt = sum[WIDTH-1:0];
        cy  = sum[WIDTH];
      end
      OP_AND: nxt = a & b;
      OP_OR:  nxt = a | b;
      OP_MUL: nxt = b[0] ? acc + a : acc;
      OP_SRA: begin
        if (cnt != '0) nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
      end
      OP_ROR: begin
        if (cnt != '0) nxt = {acc[0], acc[WIDTH-1:1]};
      end
      OP_SHIFT: begin
        if (cnt != '0)
          nxt = choice ? {1'b0, acc[WIDTH-1:1]}
                       : {acc[WIDTH-2:0], 1'b0};
      end
      default: nxt = acc;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      op     <= OP_FWD;
      choice <= 1'b0;
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      cnt    <= '0;
      RESULT <= '0;
      ZERO   <= 1'b1;
      CARRY  <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            op     <= op_t'(SELECT);
            choice <= CHOICE;
            a      <= DATA1;
            b      <= DATA2;
            acc    <= (op_t'(SELECT) == OP_MUL) ? '0 : DATA1;
            cnt    <= load_cnt;
            BUSY   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          acc <= nxt;
          a   <= a << 1;
          b   <= b >> 1;
          cnt <= (cnt == '0) ? '0 : cnt - SHAMT_W'(1);
          if (last) begin
            RESULT <= nxt;
            ZERO   <= (nxt == '0);
            CARRY  <= cy;
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
